mem_stage: RTL and testbench

- Consumer end of the EX-stage result interface for the 16-bit pipelined processor.
- Captures EX outputs (ALU result, branch target, Zero) under a valid/ready handshake and resolves branches (pc_src, flush).
- Performs load/store through a request/acknowledge data-memory port using a small FSM.
- Presents one write-back record per accepted EX op to the WB stage.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/mem_capture_reg.sv | 31 +++
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, MEM-stage FSM encoding and the EX-capture record.
package cpu_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     branch_target;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  zero;
    } ex_cap_t;

endpackage

// File: rtl/mem_capture_reg.sv
// Enable-loaded register holding the accepted EX-stage record.
module mem_capture_reg
    import cpu_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    input  logic    en,
    input  ex_cap_t d,
    output ex_cap_t q
);

    ex_cap_t cap_d, cap_q;

    always_comb begin
        cap_d = cap_q;
        if (en) begin
            cap_d = d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    assign q = cap_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX capture, branch resolution, req/ack data-memory FSM, WB record.
// Optional request timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W         = cpu_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W     = cpu_pkg::REG_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     branch_target,
    input  logic                  zero,
    input  logic                  branch,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_W-1:0]     store_data,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    output logic                  pc_src,
    output logic [DATA_W-1:0]     pc_branch,
    output logic                  flush,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  mem_err
);

    mem_state_e            state_d, state_q;
    ex_cap_t               cap_in, cap;
    logic                  accept;
    logic                  acc_d, acc_q;
    logic                  wb_valid_d, wb_valid_q;
    logic                  wb_reg_write_d, wb_reg_write_q;
    logic [REG_ADDR_W-1:0] wb_write_reg_d, wb_write_reg_q;
    logic [DATA_W-1:0]     wb_data_d, wb_data_q;
    logic [DATA_W-1:0]     mem_data_d, mem_data_q;
    logic                  mem_err_d, mem_err_q;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_d, cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Gate with reset so ex_ready reads 0 while reset is held.
    assign ex_ready = reset_n & (state_q == StIdle);
    assign accept   = ex_valid & ex_ready;

    assign cap_in = '{
        alu_result:    alu_result,
        branch_target: branch_target,
        store_data:    store_data,
        write_reg:     write_reg,
        reg_write:     reg_write,
        mem_read:      mem_read,
        mem_write:     mem_write,
        branch:        branch,
        zero:          zero
    };

    mem_capture_reg u_capture (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (accept),
        .d       (cap_in),
        .q       (cap)
    );

    always_comb begin
        state_d        = state_q;
        acc_d          = accept;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_write_reg_d = wb_write_reg_q;
        wb_data_d      = wb_data_q;
        mem_data_d     = mem_data_q;
        mem_err_d      = mem_err_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == StAccess) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (mem_read || mem_write) begin
                        state_d = StAccess;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = alu_result;
                        wb_reg_write_d = reg_write;
                        wb_write_reg_d = write_reg;
                    end
                end
            end
            StAccess: begin
                if (dmem_ack) begin
                    state_d = StResp;
                    // A store wins when both mem flags are set.
                    mem_data_d = (cap.mem_read && !cap.mem_write) ? dmem_rdata : cap.alu_result;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d        = StIdle;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = cap.alu_result;
                    wb_reg_write_d = 1'b0;
                    wb_write_reg_d = cap.write_reg;
                    mem_err_d      = 1'b1;
`endif
                end
            end
            StResp: begin
                state_d        = StIdle;
                wb_valid_d     = 1'b1;
                wb_data_d      = mem_data_q;
                wb_reg_write_d = cap.reg_write;
                wb_write_reg_d = cap.write_reg;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            acc_q          <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_write_reg_q <= '0;
            wb_data_q      <= '0;
            mem_data_q     <= '0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_write_reg_q <= wb_write_reg_d;
            wb_data_q      <= wb_data_d;
            mem_data_q     <= mem_data_d;
            mem_err_q      <= mem_err_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign pc_src    = acc_q & cap.branch & cap.zero;
    assign flush     = pc_src;
    assign pc_branch = cap.branch_target;

    // Request outputs derive from state so reset drops them immediately.
    assign dmem_req   = (state_q == StAccess);
    assign dmem_we    = dmem_req & cap.mem_write;
    assign dmem_addr  = dmem_req ? cap.alu_result : '0;
    assign dmem_wdata = dmem_req ? cap.store_data : '0;

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_write_reg = wb_write_reg_q;
    assign wb_data      = wb_data_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; timeout case needs MEM_TIMEOUT_EN.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_ready;
    logic [15:0] alu_result, branch_target, store_data;
    logic        zero, branch, mem_read, mem_write, reg_write;
    logic [2:0]  write_reg;
    logic        pc_src, flush;
    logic [15:0] pc_branch;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_reg_write, mem_err;
    logic [2:0]  wb_write_reg;
    logic [15:0] wb_data;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 clock = ~clock;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .alu_result    (alu_result),
        .branch_target (branch_target),
        .zero          (zero),
        .branch        (branch),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .store_data    (store_data),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .pc_src        (pc_src),
        .pc_branch     (pc_branch),
        .flush         (flush),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_data       (wb_data),
        .mem_err       (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_op();
        ex_valid = 0; alu_result = '0; branch_target = '0; store_data = '0;
        zero = 0; branch = 0; mem_read = 0; mem_write = 0; reg_write = 0; write_reg = '0;
    endtask

    task automatic issue(input logic [15:0] alu, input logic rd, input logic wr,
                         input logic [15:0] sd, input logic rw, input logic [2:0] wreg);
        clear_op();
        ex_valid = 1; alu_result = alu; mem_read = rd; mem_write = wr;
        store_data = sd; reg_write = rw; write_reg = wreg;
    endtask

    initial begin
        reset_n = 0; dmem_ack = 0; dmem_rdata = '0;
        clear_op();
        #3;
        check("rst_ex_ready", ex_ready, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_pc_src", pc_src, 0);
        check("rst_mem_err", mem_err, 0);
        #9 reset_n = 1;
        #1 check("post_rst_ready", ex_ready, 1);
        tick();

        // ALU op completes next cycle
        issue(16'h1234, 0, 0, 16'h0, 1, 3'd5);
        tick();
        clear_op();
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_data", wb_data, 16'h1234);
        check("alu_wb_reg", wb_write_reg, 5);
        check("alu_wb_rw", wb_reg_write, 1);
        check("alu_ready", ex_ready, 1);
        check("alu_pc_src", pc_src, 0);
        tick();
        check("alu_wb_pulse", wb_valid, 0);

        // Branch taken, then not taken
        issue(16'h0, 0, 0, 16'h0, 0, 3'd0);
        branch = 1; zero = 1; branch_target = 16'h0040;
        tick();
        clear_op();
        check("br_pc_src", pc_src, 1);
        check("br_flush", flush, 1);
        check("br_target", pc_branch, 16'h0040);
        tick();
        check("br_pulse", pc_src, 0);
        issue(16'h0, 0, 0, 16'h0, 0, 3'd0);
        branch = 1; zero = 0; branch_target = 16'h0040;
        tick();
        clear_op();
        check("br_nt_pc_src", pc_src, 0);
        check("br_nt_flush", flush, 0);
        tick();

        // Load, ack on third request cycle
        issue(16'h0010, 1, 0, 16'h0, 1, 3'd2);
        tick();
        clear_op();
        for (int i = 0; i < 3; i++) begin
            check("ld_req", dmem_req, 1);
            check("ld_we", dmem_we, 0);
            check("ld_addr", dmem_addr, 16'h0010);
            check("ld_ready", ex_ready, 0);
            if (i == 2) begin
                dmem_ack = 1; dmem_rdata = 16'hBEEF;
            end
            tick();
        end
        dmem_ack = 0; dmem_rdata = '0;
        check("ld_req_drop", dmem_req, 0);
        check("ld_resp_ready", ex_ready, 0);
        check("ld_resp_wbv", wb_valid, 0);
        tick();
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_data", wb_data, 16'hBEEF);
        check("ld_wb_reg", wb_write_reg, 2);
        check("ld_wb_rw", wb_reg_write, 1);
        check("ld_idle_ready", ex_ready, 1);
        tick();

        // Store with both mem flags set, immediate ack
        issue(16'h0020, 1, 1, 16'h00AA, 0, 3'd4);
        tick();
        clear_op();
        check("st_req", dmem_req, 1);
        check("st_we", dmem_we, 1);
        check("st_addr", dmem_addr, 16'h0020);
        check("st_wdata", dmem_wdata, 16'h00AA);
        dmem_ack = 1; dmem_rdata = 16'h5555;
        tick();
        dmem_ack = 0;
        check("st_req_drop", dmem_req, 0);
        tick();
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_rw", wb_reg_write, 0);
        check("st_wb_data", wb_data, 16'h0020);
        // Spurious ack in IDLE
        dmem_ack = 1; dmem_rdata = 16'h1111;
        tick();
        dmem_ack = 0;
        check("spur_req", dmem_req, 0);
        check("spur_wbv", wb_valid, 0);
        check("spur_ready", ex_ready, 1);
        tick();

        // Reset during an access
        issue(16'h0030, 1, 0, 16'h0, 1, 3'd1);
        tick();
        clear_op();
        check("rm_req", dmem_req, 1);
        #2 reset_n = 0;
        #1 check("rm_req_async", dmem_req, 0);
        check("rm_ready", ex_ready, 0);
        #3 reset_n = 1;
        dmem_ack = 1; dmem_rdata = 16'hDEAD;
        tick();
        dmem_ack = 0;
        check("rm_late_req", dmem_req, 0);
        check("rm_late_wbv", wb_valid, 0);
        tick();
        check("rm_late_wbv2", wb_valid, 0);
        issue(16'h55AA, 0, 0, 16'h0, 1, 3'd7);
        tick();
        clear_op();
        check("rm_alu_wbv", wb_valid, 1);
        check("rm_alu_data", wb_data, 16'h55AA);
        check("rm_alu_reg", wb_write_reg, 7);
        tick();

`ifdef MEM_TIMEOUT_EN
        // Request never acknowledged
        issue(16'h0040, 1, 0, 16'h0, 1, 3'd3);
        tick();
        clear_op();
        for (int i = 0; i < 4; i++) begin
            check("to_req", dmem_req, 1);
            check("to_err_pre", mem_err, 0);
            tick();
        end
        check("to_req_drop", dmem_req, 0);
        check("to_wbv", wb_valid, 1);
        check("to_wb_rw", wb_reg_write, 0);
        check("to_err", mem_err, 1);
        check("to_ready", ex_ready, 1);
        issue(16'h0001, 0, 0, 16'h0, 1, 3'd1);
        tick();
        clear_op();
        check("to_after_wbv", wb_valid, 1);
        tick();
        check("to_sticky", mem_err, 1);
`else
        check("no_to_err", mem_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
